// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Bus master that runs one complete ALU operation per request. A request
// (opcode, A, B, optional flags) is accepted on a valid/ready port. The
// sequencer then drives the ALU command sequence on the shared bus:
// latch A, latch B, latch Op, optionally latch F, compute, read Y, read F.
// The result word and flags are returned on a valid/ready response port.
//
// Handshake rule (request and response ports): a transfer happens at a
// rising edge of i_Clk where valid and ready are both 1. A response, once
// valid, holds o_rsp_y / o_rsp_flags / o_rsp_error stable until it is taken.
//
// Optional feature macro: ALU_SEQ_TIMEOUT_EN
//   defined   : RDY/RDF give up after TIMEOUT consecutive cycles without
//               i_bus_valid and respond with o_rsp_error=1, y=0, flags=0.
//   undefined : RDY/RDF wait indefinitely; o_rsp_error is tied to 0.
//
// Ports
//   i_Clk, i_Reset          clock, synchronous active-high reset
//   i_req_valid/o_req_ready request handshake
//   i_req_op/a/b            opcode and operands
//   i_req_load_flags/flags  optional F-register preload
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_y/flags/error     result word, ALU flags, read-timeout marker
//   o_bus_command/data/valid  command and write data towards the ALU
//   i_bus_data/valid        read data from the ALU
//   dbg_state               current FSM state (debug observation only)

module alu_sequencer #(
  parameter int WORDSIZE = 16,
  parameter int CMD_W    = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [3:0]          i_req_op,
  input  logic [WORDSIZE-1:0] i_req_a,
  input  logic [WORDSIZE-1:0] i_req_b,
  input  logic                i_req_load_flags,
  input  logic [7:0]          i_req_flags,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WORDSIZE-1:0] o_rsp_y,
  output logic [7:0]          o_rsp_flags,
  output logic                o_rsp_error,
  output logic [CMD_W-1:0]    o_bus_command,
  output logic [WORDSIZE-1:0] o_bus_data,
  output logic                o_bus_valid,
  input  logic [WORDSIZE-1:0] i_bus_data,
  input  logic                i_bus_valid,
  output logic [3:0]          dbg_state
);

  // ALU bus command codes.
  localparam logic [CMD_W-1:0] COM_NONE    = CMD_W'(0);
  localparam logic [CMD_W-1:0] COM_LATCHA  = CMD_W'(1);
  localparam logic [CMD_W-1:0] COM_LATCHB  = CMD_W'(2);
  localparam logic [CMD_W-1:0] COM_LATCHOP = CMD_W'(3);
  localparam logic [CMD_W-1:0] COM_LATCHF  = CMD_W'(4);
  localparam logic [CMD_W-1:0] COM_COMPUTE = CMD_W'(5);
  localparam logic [CMD_W-1:0] COM_OUTPUTY = CMD_W'(6);
  localparam logic [CMD_W-1:0] COM_OUTPUTF = CMD_W'(7);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LA   = 4'd1,
    S_LB   = 4'd2,
    S_LOP  = 4'd3,
    S_LF   = 4'd4,
    S_CMP  = 4'd5,
    S_RDY  = 4'd6,
    S_RDF  = 4'd7,
    S_RESP = 4'd8
  } state_t;

  state_t state;
  state_t state_next;

  // Request fields, captured only at acceptance.
  logic [3:0]          op_q;
  logic [WORDSIZE-1:0] a_q;
  logic [WORDSIZE-1:0] b_q;
  logic [7:0]          flags_in_q;
  logic                load_flags_q;

  // Response registers.
  logic [WORDSIZE-1:0] y_q;
  logic [7:0]          flags_q;

  logic accept;
  logic tmo;   // read state gives up this cycle

  assign accept    = (state == S_IDLE) && i_req_valid;
  assign dbg_state = state;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] tmr;
  logic             error_q;
  logic             in_read;

  assign in_read = (state == S_RDY) || (state == S_RDF);
  // The TIMEOUT-th consecutive stall cycle is the one that leaves.
  assign tmo     = in_read && !i_bus_valid && (tmr == TMR_W'(TIMEOUT - 1));

  // Stall counter restarts whenever the state changes, so RDY and RDF each
  // get their own full budget.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      tmr <= '0;
    end else if (state_next != state) begin
      tmr <= '0;
    end else if (in_read && !i_bus_valid) begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if (tmo) begin
      error_q <= 1'b1;
    end
  end

  assign o_rsp_error = error_q;
`else
  assign tmo         = 1'b0;
  assign o_rsp_error = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      flags_in_q   <= '0;
      load_flags_q <= 1'b0;
      y_q          <= '0;
      flags_q      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q         <= i_req_op;
        a_q          <= i_req_a;
        b_q          <= i_req_b;
        flags_in_q   <= i_req_flags;
        load_flags_q <= i_req_load_flags;
        // Start every operation from a clean result so a timed-out read
        // reports y=0 / flags=0.
        y_q          <= '0;
        flags_q      <= '0;
      end
      if ((state == S_RDY) && i_bus_valid) begin
        y_q <= i_bus_data;
      end
      if ((state == S_RDF) && i_bus_valid) begin
        flags_q <= i_bus_data[7:0];
      end
      if (tmo) begin
        y_q     <= '0;
        flags_q <= '0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_req_valid) state_next = S_LA;
      S_LA:   state_next = S_LB;
      S_LB:   state_next = S_LOP;
      S_LOP:  state_next = load_flags_q ? S_LF : S_CMP;
      S_LF:   state_next = S_CMP;
      S_CMP:  state_next = S_RDY;
      S_RDY: begin
        if (i_bus_valid) begin
          state_next = S_RDF;
        end else if (tmo) begin
          state_next = S_RESP;   // a timed-out Y read skips the F read
        end
      end
      S_RDF:  if (i_bus_valid || tmo) state_next = S_RESP;
      S_RESP: if (i_rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state; forced idle while in reset.
  always_comb begin
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_bus_command = COM_NONE;
    o_bus_data    = '0;
    o_bus_valid   = 1'b0;
    case (state)
      S_IDLE: o_req_ready = 1'b1;
      S_LA: begin
        o_bus_command = COM_LATCHA;
        o_bus_data    = a_q;
        o_bus_valid   = 1'b1;
      end
      S_LB: begin
        o_bus_command = COM_LATCHB;
        o_bus_data    = b_q;
        o_bus_valid   = 1'b1;
      end
      S_LOP: begin
        o_bus_command = COM_LATCHOP;
        o_bus_data    = WORDSIZE'(op_q);
        o_bus_valid   = 1'b1;
      end
      S_LF: begin
        o_bus_command = COM_LATCHF;
        o_bus_data    = WORDSIZE'(flags_in_q);
        o_bus_valid   = 1'b1;
      end
      S_CMP:  o_bus_command = COM_COMPUTE;
      S_RDY:  o_bus_command = COM_OUTPUTY;
      S_RDF:  o_bus_command = COM_OUTPUTF;
      S_RESP: o_rsp_valid   = 1'b1;
      default: ;
    endcase
    if (i_Reset) begin
      o_req_ready   = 1'b0;
      o_rsp_valid   = 1'b0;
      o_bus_command = COM_NONE;
      o_bus_data    = '0;
      o_bus_valid   = 1'b0;
    end
  end

  assign o_rsp_y     = y_q;
  assign o_rsp_flags = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a small ALU bus model answers the sequencer,
// a reference function predicts each result, and a scoreboard queue holds
// expected responses from request to response.

module tb_alu_sequencer;

  localparam int TIMEOUT = 15;

  localparam logic [3:0] COM_NONE    = 4'd0;
  localparam logic [3:0] COM_LATCHA  = 4'd1;
  localparam logic [3:0] COM_LATCHB  = 4'd2;
  localparam logic [3:0] COM_LATCHOP = 4'd3;
  localparam logic [3:0] COM_LATCHF  = 4'd4;
  localparam logic [3:0] COM_COMPUTE = 4'd5;
  localparam logic [3:0] COM_OUTPUTY = 4'd6;
  localparam logic [3:0] COM_OUTPUTF = 4'd7;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;

  localparam int F_CARRY = 0;
  localparam int F_ZERO  = 1;
  localparam int F_NEG   = 2;

  logic        i_Clk;
  logic        i_Reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_req_op;
  logic [15:0] i_req_a;
  logic [15:0] i_req_b;
  logic        i_req_load_flags;
  logic [7:0]  i_req_flags;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [15:0] o_rsp_y;
  logic [7:0]  o_rsp_flags;
  logic        o_rsp_error;
  logic [3:0]  o_bus_command;
  logic [15:0] o_bus_data;
  logic        o_bus_valid;
  logic [15:0] i_bus_data;
  logic        i_bus_valid;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [24:0] exp_q[$];   // {error, flags, y}

  alu_sequencer #(.WORDSIZE(16), .CMD_W(4), .TIMEOUT(TIMEOUT)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .i_req_load_flags(i_req_load_flags), .i_req_flags(i_req_flags),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_y(o_rsp_y), .o_rsp_flags(o_rsp_flags), .o_rsp_error(o_rsp_error),
    .o_bus_command(o_bus_command), .o_bus_data(o_bus_data),
    .o_bus_valid(o_bus_valid), .i_bus_data(i_bus_data),
    .i_bus_valid(i_bus_valid), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // ---------------- reference ALU ----------------
  function automatic logic [23:0] alu_ref(input logic [3:0] op,
                                          input logic [15:0] a, b,
                                          input logic cin);
    logic [16:0] s;
    logic [7:0]  f;
    case (op)
      ALU_ADD: s = {1'b0, a} + {1'b0, b};
      ALU_ADC: s = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      ALU_SUB: s = {1'b0, a} - {1'b0, b};
      ALU_AND: s = {1'b0, a & b};
      ALU_OR:  s = {1'b0, a | b};
      ALU_XOR: s = {1'b0, a ^ b};
      default: s = 17'h0;
    endcase
    f          = 8'h00;
    f[F_CARRY] = s[16];
    f[F_ZERO]  = (s[15:0] == 16'h0);
    f[F_NEG]   = s[15];
    return {f, s[15:0]};
  endfunction

  // ---------------- ALU bus model ----------------
  logic [15:0] alu_a = '0, alu_b = '0, alu_y = '0;
  logic [3:0]  alu_op = '0;
  logic [7:0]  alu_f = '0;
  int          stall_left = 0;

  always @(posedge i_Clk) begin
    if (o_bus_valid) begin
      case (o_bus_command)
        COM_LATCHA:  alu_a  <= o_bus_data;
        COM_LATCHB:  alu_b  <= o_bus_data;
        COM_LATCHOP: alu_op <= o_bus_data[3:0];
        COM_LATCHF:  alu_f  <= o_bus_data[7:0];
        default: ;
      endcase
    end
    if (o_bus_command == COM_COMPUTE)
      {alu_f, alu_y} <= alu_ref(alu_op, alu_a, alu_b, alu_f[F_CARRY]);
    if (o_bus_command == COM_OUTPUTY && stall_left > 0)
      stall_left <= stall_left - 1;
  end

  assign i_bus_valid = ((o_bus_command == COM_OUTPUTY) && (stall_left == 0)) ||
                       (o_bus_command == COM_OUTPUTF);
  assign i_bus_data  = (o_bus_command == COM_OUTPUTY) ? alu_y :
                       (o_bus_command == COM_OUTPUTF) ? {8'h00, alu_f} : 16'h0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tr(input logic [3:0] cmd, input logic v,
                                     input logic [15:0] d);
    return {11'h0, v, cmd, d};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"},
          {o_req_ready, o_rsp_valid, o_rsp_error, o_bus_valid, o_bus_command,
           o_bus_data, o_rsp_flags},
          {1'b0, 1'b0, 1'b0, 1'b0, COM_NONE, 16'h0, 8'h00});
    check({tag, "_y"}, o_rsp_y, 16'h0);
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [15:0] a, b, input logic lf,
                        input logic [7:0] f, input int stall, input int hold);
    logic [23:0] r;
    logic [24:0] exp;
    logic [24:0] got;
    logic [31:0] exp_tr[$];
    logic [31:0] got_tr[$];
    int cyc, lat, n_y;
    bit timed_out;

    r = alu_ref(op, a, b, lf ? f[F_CARRY] : 1'b0);
`ifdef ALU_SEQ_TIMEOUT_EN
    timed_out = (stall >= TIMEOUT);
`else
    timed_out = 1'b0;
`endif
    exp = timed_out ? {1'b1, 24'h0} : {1'b0, r};

    exp_tr.push_back(tr(COM_LATCHA, 1'b1, a));
    exp_tr.push_back(tr(COM_LATCHB, 1'b1, b));
    exp_tr.push_back(tr(COM_LATCHOP, 1'b1, {12'h0, op}));
    if (lf) exp_tr.push_back(tr(COM_LATCHF, 1'b1, {8'h00, f}));
    exp_tr.push_back(tr(COM_COMPUTE, 1'b0, 16'h0));
    n_y = timed_out ? TIMEOUT : stall + 1;
    for (int i = 0; i < n_y; i++) exp_tr.push_back(tr(COM_OUTPUTY, 1'b0, 16'h0));
    if (!timed_out) exp_tr.push_back(tr(COM_OUTPUTF, 1'b0, 16'h0));
    lat = exp_tr.size() + 1;

    cyc = 0;
    while (!o_req_ready && cyc < 20) begin
      @(negedge i_Clk);
      cyc++;
    end
    check({tag, "_req_ready"}, o_req_ready, 1);

    i_req_valid      = 1'b1;
    i_req_op         = op;
    i_req_a          = a;
    i_req_b          = b;
    i_req_load_flags = lf;
    i_req_flags      = f;
    i_rsp_ready      = (hold == 0);
    stall_left       = stall;
    exp_q.push_back(exp);

    @(negedge i_Clk);   // acceptance edge E0 has passed: cycle 1
    i_req_valid      = 1'b0;
    i_req_op         = 4'($urandom_range(0, 15));
    i_req_a          = 16'($urandom);
    i_req_b          = 16'($urandom);
    i_req_load_flags = 1'($urandom_range(0, 1));
    i_req_flags      = 8'($urandom);

    cyc = 1;
    while (!o_rsp_valid && cyc < lat + 10) begin
      got_tr.push_back(tr(o_bus_command, o_bus_valid, o_bus_data));
      @(negedge i_Clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, lat);
    for (int i = 0; i < exp_tr.size(); i++)
      check($sformatf("%s_bus%0d", tag, i),
            (i < got_tr.size()) ? got_tr[i] : 32'hFFFF_FFFF, exp_tr[i]);

    for (int h = 0; h < hold; h++) begin
      check($sformatf("%s_hold%0d_ctl", tag, h),
            {o_rsp_valid, o_req_ready, o_bus_valid, o_bus_command},
            {1'b1, 1'b0, 1'b0, COM_NONE});
      check($sformatf("%s_hold%0d_val", tag, h),
            {o_rsp_error, o_rsp_flags, o_rsp_y},
            (exp_q.size() > 0) ? exp_q[0] : 25'h1FF_FFFF);
      @(negedge i_Clk);
    end
    i_rsp_ready = 1'b1;

    check({tag, "_rsp_valid"}, o_rsp_valid, 1);
    got = {o_rsp_error, o_rsp_flags, o_rsp_y};
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, got, 25'h1FF_FFFF);
    end else begin
      check({tag, "_result"}, got, exp_q.pop_front());
    end

    @(negedge i_Clk);
    check({tag, "_idle"}, {o_rsp_valid, o_req_ready}, 2'b01);
    stall_left = 0;
  endtask

  // ---------------- reset in the middle of an operation ----------------
  task automatic reset_mid_op();
    int cyc;
    int seen;
    i_req_valid      = 1'b1;
    i_req_op         = ALU_ADD;
    i_req_a          = 16'h1111;
    i_req_b          = 16'h2222;
    i_req_load_flags = 1'b0;
    i_req_flags      = 8'h00;
    @(negedge i_Clk);
    i_req_valid = 1'b0;
    cyc = 0;
    while (o_bus_command != COM_COMPUTE && cyc < 10) begin
      @(negedge i_Clk);
      cyc++;
    end
    check("rst_mid_reached_cmp", o_bus_command, COM_COMPUTE);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    check_reset_outputs("rst_mid_during");
    check("rst_mid_state", dbg_state, 4'd0);
    i_Reset = 1'b0;
    @(negedge i_Clk);
    check("rst_mid_ready_after", {o_req_ready, o_rsp_valid}, 2'b10);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_rsp_valid) seen++;
      @(negedge i_Clk);
    end
    check("rst_mid_no_rsp", seen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] ops[5];
    ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND;
    ops[3] = ALU_OR;  ops[4] = ALU_XOR;

    i_Reset          = 1'b1;
    i_req_valid      = 1'b0;
    i_req_op         = '0;
    i_req_a          = '0;
    i_req_b          = '0;
    i_req_load_flags = 1'b0;
    i_req_flags      = '0;
    i_rsp_ready      = 1'b1;

    repeat (2) @(negedge i_Clk);
    check_reset_outputs("reset");
    i_Reset = 1'b0;
    @(negedge i_Clk);
    check("reset_ready_after", {o_req_ready, o_rsp_valid}, 2'b10);

    run_op("add", ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 8'h00, 0, 0);
    run_op("adc_lf", ALU_ADC, 16'h0002, 16'h0003, 1'b1, 8'h01, 0, 0);
    run_op("bp", ALU_SUB, 16'h0005, 16'h0009, 1'b0, 8'h00, 0, 5);
    reset_mid_op();
    run_op("xor", ALU_XOR, 16'h00F0, 16'h0FF0, 1'b0, 8'h00, 0, 0);
    run_op("stall", ALU_XOR, 16'h1234, 16'h0000, 1'b0, 8'h00, 20, 0);
    run_op("lf_after_stall", ALU_OR, 16'h8000, 16'h0001, 1'b1, 8'hA5, 1, 0);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 4)],
             16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
